// File: rtl/sweeper_pkg.sv
// Shared types and helpers for the truth-table sweeper.
package sweeper_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Increment that sticks at the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] count, input int unsigned width);
    logic [31:0] max_v;
    if (width >= 32'd32) begin
      max_v = 32'hFFFF_FFFF;
    end else begin
      max_v = (32'd1 << width) - 32'd1;
    end
    if (count >= max_v) begin
      sat_inc = max_v;
    end else begin
      sat_inc = count + 32'd1;
    end
  endfunction

endpackage

// File: rtl/vec_delay_line.sv
// Delays {valid, vec} by DUT_LAT cycles so the compare lines up with the cell's response.
module vec_delay_line #(
  parameter int N_IN    = 3,
  parameter int DUT_LAT = 0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            valid_i,
  input  logic [N_IN-1:0] vec_i,
  output logic            valid_o,
  output logic [N_IN-1:0] vec_o
);

  if (DUT_LAT == 0) begin : g_pass
    logic unused_clk_rst_s;
    assign unused_clk_rst_s = clock ^ reset;
    assign valid_o = valid_i;
    assign vec_o   = vec_i;
  end else begin : g_pipe
    logic [DUT_LAT-1:0] valid_q;
    logic [N_IN-1:0]    vec_q [DUT_LAT];

    // Shift stage s takes stage s-1; clearing valid bits drops anything in flight.
    always_ff @(posedge clock) begin
      if (reset) begin
        valid_q <= '0;
        for (int s = 0; s < DUT_LAT; s++) begin
          vec_q[s] <= '0;
        end
      end else begin
        valid_q[0] <= valid_i;
        vec_q[0]   <= vec_i;
        for (int s = 1; s < DUT_LAT; s++) begin
          valid_q[s] <= valid_q[s-1];
          vec_q[s]   <= vec_q[s-1];
        end
      end
    end

    assign valid_o = valid_q[DUT_LAT-1];
    assign vec_o   = vec_q[DUT_LAT-1];
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive self-test engine: sweeps all input vectors into a cell and checks its
// response against TRUTH_TABLE, counting mismatches and capturing the first failure.
module truth_table_sweeper
  import sweeper_pkg::*;
#(
  parameter int                   N_IN        = 3,
  parameter logic [(1<<N_IN)-1:0] TRUTH_TABLE = 8'b00111001,
  parameter int                   DUT_LAT     = 0,
  parameter int                   ERR_W       = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             continuous,
  input  logic             stop,
  output logic [N_IN-1:0]  x,
  input  logic             z,
  output logic             error,
  output logic [ERR_W-1:0] err_count,
  output logic [N_IN-1:0]  first_fail_vec,
  output logic             first_fail_valid,
  output logic             busy,
  output logic             done
);

  localparam logic [N_IN-1:0] VEC_MAX    = '1;
  localparam logic [2:0]      DRAIN_INIT = (DUT_LAT > 0) ? 3'(DUT_LAT - 1) : 3'd0;

  state_e           state_q, state_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic             cont_q, cont_d;
  logic             stop_q, stop_d;
  logic [2:0]       drain_q, drain_d;
  logic             error_q, error_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             ffv_q, ffv_d;
  logic [N_IN-1:0]  ffvec_q, ffvec_d;
  logic             cmp_valid_s;
  logic [N_IN-1:0]  cmp_vec_s;
  logic             mismatch_s;
  logic             last_cmp_s;

  vec_delay_line #(
    .N_IN    (N_IN),
    .DUT_LAT (DUT_LAT)
  ) u_delay (
    .clock   (clock),
    .reset   (reset),
    .valid_i (state_q == SWEEP),
    .vec_i   (vec_q),
    .valid_o (cmp_valid_s),
    .vec_o   (cmp_vec_s)
  );

  assign mismatch_s = cmp_valid_s && (z != TRUTH_TABLE[cmp_vec_s]);
  assign last_cmp_s = cmp_valid_s && (cmp_vec_s == VEC_MAX);

  // Sequencer: vec_q doubles as the stimulus and is only non-zero while sweeping.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cont_d  = cont_q;
    stop_d  = stop_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SWEEP;
          vec_d   = '0;
          cont_d  = continuous;
          stop_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      SWEEP: begin
        if (stop) begin
          stop_d = 1'b1;
        end else begin
          stop_d = stop_q;
        end
        if (vec_q == VEC_MAX) begin
          vec_d = '0;
          if (cont_q && !stop_q && !stop) begin
            state_d = SWEEP;
          end else if (DUT_LAT > 0) begin
            state_d = DRAIN;
            drain_d = DRAIN_INIT;
          end else begin
            state_d = DONE;
          end
        end else begin
          vec_d = vec_q + N_IN'(1);
        end
      end
      DRAIN: begin
        if (drain_q == 3'd0) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q - 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Result bookkeeping; start clears the tally, only the first mismatch is captured.
  always_comb begin
    err_cnt_d = err_cnt_q;
    ffv_d     = ffv_q;
    ffvec_d   = ffvec_q;
    error_d   = mismatch_s;
    done_d    = last_cmp_s;
    busy_d    = (state_d == SWEEP) || (state_d == DRAIN);
    if ((state_q == IDLE) && start) begin
      err_cnt_d = '0;
      ffv_d     = 1'b0;
    end else if (mismatch_s) begin
      err_cnt_d = ERR_W'(sat_inc(32'(err_cnt_q), ERR_W));
      if (!ffv_q) begin
        ffv_d   = 1'b1;
        ffvec_d = cmp_vec_s;
      end else begin
        ffv_d   = 1'b1;
      end
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      vec_q     <= '0;
      cont_q    <= 1'b0;
      stop_q    <= 1'b0;
      drain_q   <= 3'd0;
      error_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_cnt_q <= '0;
      ffv_q     <= 1'b0;
      ffvec_q   <= '0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      cont_q    <= cont_d;
      stop_q    <= stop_d;
      drain_q   <= drain_d;
      error_q   <= error_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      err_cnt_q <= err_cnt_d;
      ffv_q     <= ffv_d;
      ffvec_q   <= ffvec_d;
    end
  end

  assign x                = vec_q;
  assign error            = error_q;
  assign err_count        = err_cnt_q;
  assign first_fail_vec   = ffvec_q;
  assign first_fail_valid = ffv_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Parametrised self-test engine for an N-input, 1-output combinational or pipelined logic cell. On `start` it drives every input vector 0..2^N_IN−1 onto `x`, compares the cell's response `z` against the `TRUTH_TABLE` parameter after `DUT_LAT` cycles, and counts mismatches. It records the first failing vector and supports single-sweep and continuous modes. It sits beside the cell under test in lab test harnesses, in place of per-cell hand-written `error` comparators.

## Interface
- `N_IN`, 3: number of cell inputs; 1..8
- `TRUTH_TABLE`, 8'b00111001: expected output; bit k = expected `z` for `x == k`; width 2^N_IN
- `DUT_LAT`, 0: cell latency in clock cycles; 0..7
- `ERR_W`, 8: error counter width

Ports:
- `clock`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  begin sweep; sampled only in IDLE
- `continuous`  in  1  mode select; sampled together with `start`
- `stop`  in  1  in continuous mode, finish the current sweep and then halt
- `x`  out  N_IN  stimulus vector to the cell
- `z`  in  1  cell response
- `error`  out  1  one-cycle pulse per mismatching vector
- `err_count`  out  ERR_W  saturating mismatch count
- `first_fail_vec`  out  N_IN  first mismatching vector since `start`
- `first_fail_valid`  out  1  `first_fail_vec` holds a valid value
- `busy`  out  1  sweep or drain in progress
- `done`  out  1  one-cycle pulse at the end of each sweep

## Operation
- States:
  - IDLE → SWEEP on `start`.
  - SWEEP: `x` = vec, vec increments by 1 every cycle.
  - After vec = 2^N_IN−1:
    - Continuous and no stop latched: stay in SWEEP, vec wraps to 0, no gap.
    - Otherwise: go to DRAIN if `DUT_LAT` > 0, else DONE.
  - DRAIN: `x` = 0. Runs until the last outstanding compare occurs, then DONE.
  - DONE: `done` = 1 for one cycle, then IDLE.
- Compare pipeline: a valid bit plus vector is delayed `DUT_LAT` stages. The mismatch is `z != TRUTH_TABLE[delayed_vec]`, evaluated only when the delayed valid bit is 1.
- On `start`:
  - `err_count` clears to 0.
  - `first_fail_valid` clears to 0.
  - The `continuous` value is latched.
- `err_count` saturates at 2^ERR_W−1. In continuous mode it accumulates across sweeps.
- `first_fail_vec` and `first_fail_valid` are written on the first mismatch only. They hold until the next `start`.
- `stop`:
  - Latched while `busy`.
  - Ignored in single-sweep mode.
  - Does not truncate a sweep in progress.
- `start` while `busy` is ignored.
- Outside SWEEP, `x` = 0.
- `reset` (any state, mid-sweep included) at the next edge:
  - State = IDLE, pipeline valid bits cleared.
  - All outputs = 0: `x`, `error`, `err_count`, `first_fail_vec`, `first_fail_valid`, `busy`, `done`.

## Timing
- Edge E0 samples `start` = 1 in IDLE. Let cycle k be the cycle after edge E0+k.
- Vector k is driven during cycle k, for k = 0..2^N_IN−1. `busy` = 1 from cycle 0.
- The response to vector k is sampled at edge E0+k+1+DUT_LAT.
- The `error` pulse and the `err_count` / `first_fail_*` updates appear in the cycle after that edge.
- Last compare: `done` = 1 and `busy` = 0 in the same cycle as the final vector's `error` pulse. That cycle is cycle 2^N_IN+DUT_LAT after E0.
- Continuous mode:
  - `done` pulses every 2^N_IN cycles.
  - `busy` stays high until the final drain completes.
  - After `done`, a new `start` is accepted no earlier than the next cycle (IDLE).

## Structure
- Shared package `sweeper_pkg` holds:
  - The state enum (IDLE, SWEEP, DRAIN, DONE).
  - Helper function `sat_inc(count, width)`.
- Sub-module `vec_delay_line`: DUT_LAT-stage shift register of {valid, vec}, with synchronous clear on `reset`. When DUT_LAT = 0 it is a pass-through.
- Top level contains the FSM, vector counter, comparator, error counter and first-fail capture.

## Test plan
- Defaults, cell = reference function (table 00111001), single sweep → `err_count` = 0, `first_fail_valid` = 0, `done` in cycle 8.
- `z` stuck at 0 → `error` pulses for vectors 0, 3, 4, 5; `err_count` = 4; `first_fail_vec` = 0.
- DUT_LAT = 2, cell modelled as a 2-register pipeline of the correct function → `err_count` = 0; `done` in cycle 10; `x` = 0 during drain.
- Continuous, `z` stuck at 0, `stop` pulsed during the 3rd sweep → 3 `done` pulses, `err_count` = 12, then IDLE.
- ERR_W = 2, inverted cell → 8 mismatches, `err_count` saturates at 3, `first_fail_vec` = 0.
- `reset` at cycle 4 of a sweep → all outputs 0 at the next edge. A new `start` then gives a full clean sweep with correct counts. `start` pulsed while `busy` has no effect.
